bcd_serial_addsub: RTL

- Parametrised, digit-serial BCD adder/subtractor for DIGITS-digit unsigned packed-BCD operands.
- Processes one BCD digit per clock, least-significant digit first, using a single-digit adder with decimal correction.
- For subtraction it returns sign plus magnitude rather than a raw ten's-complement word.
- It is the sequential, width-generic successor to the fixed two-digit combinational add/sub in the BCD arithmetic library, and sits behind a start/done handshake.

---
 rtl/bcd_serial_addsub.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bcd_serial_addsub.sv
// rtl/bcd_serial_addsub.sv - digit-serial packed-BCD adder/subtractor with sign-magnitude result
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                op_sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] result,
    output logic                carry_out,
    output logic                negative,
    output logic                err
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic            sub_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    result_q;
    logic            carry_out_q;
    logic            negative_q;
    logic            err_q;

    logic [3:0]      a_dig;
    logic [3:0]      b_dig;
    logic [3:0]      r_dig;
    logic [3:0]      opnd_x;
    logic [3:0]      opnd_y;
    logic [4:0]      sum;
    logic [4:0]      sum_corr;
    logic [3:0]      dig_d;
    logic            carry_d;
    logic            last_dig;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        r_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
                r_dig = result_q[4*i +: 4];
            end
        end
    end

    // PASS2 forms the ten's complement of the PASS1 digits: (9 - r) plus the running carry.
    always_comb begin
        opnd_x = 4'd0;
        opnd_y = 4'd0;
        if (state_q == PASS2) begin
            opnd_x = 4'd9 - r_dig;
        end else begin
            opnd_x = a_dig;
            opnd_y = sub_q ? (4'd9 - b_dig) : b_dig;
        end
        sum      = {1'b0, opnd_x} + {1'b0, opnd_y} + {4'd0, carry_q};
        sum_corr = sum + 5'd6;
        carry_d  = (sum > 5'd9);
        dig_d    = carry_d ? sum_corr[3:0] : sum[3:0];
        last_dig = (idx_q == IW'(DIGITS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            negative_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q         <= a;
                        b_q         <= b;
                        sub_q       <= op_sub;
                        idx_q       <= '0;
                        carry_q     <= op_sub;
                        result_q    <= '0;
                        carry_out_q <= 1'b0;
                        negative_q  <= 1'b0;
                        if (has_bad_digit(a) || has_bad_digit(b)) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= PASS1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                PASS1: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx_q == IW'(i)) result_q[4*i +: 4] <= dig_d;
                    end
                    carry_q <= carry_d;
                    idx_q   <= idx_q + 1'b1;
                    if (last_dig) begin
                        if (!sub_q) begin
                            carry_out_q <= carry_d;
                            state_q     <= DONE;
                        end else if (carry_d) begin
                            state_q <= DONE;
                        end else begin
                            negative_q <= 1'b1;
                            idx_q      <= '0;
                            carry_q    <= 1'b1;
                            state_q    <= PASS2;
                        end
                    end
                end
                PASS2: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx_q == IW'(i)) result_q[4*i +: 4] <= dig_d;
                    end
                    carry_q <= carry_d;
                    idx_q   <= idx_q + 1'b1;
                    if (last_dig) state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q == PASS1) || (state_q == PASS2);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign negative  = negative_q;
    assign err       = err_q;
endmodule
